// File: rtl/switch_debounce_if.sv
// rtl/switch_debounce_if.sv - switch/debounce signal bundle; o_Release exists only under SWITCH_DEBOUNCE_RELEASE_EN
interface switch_debounce_if;
  logic [3:0] i_Switch;
  logic [3:0] o_Level;
  logic [3:0] o_Press;
`ifdef SWITCH_DEBOUNCE_RELEASE_EN
  logic [3:0] o_Release;

  modport master (output i_Switch, input o_Level, input o_Press, input o_Release);
  modport slave  (input i_Switch, output o_Level, output o_Press, output o_Release);
`else
  modport master (output i_Switch, input o_Level, input o_Press);
  modport slave  (input i_Switch, output o_Level, output o_Press);
`endif
endinterface

// File: rtl/switch_debounce.sv
// rtl/switch_debounce.sv - four independent push-button debouncers with press pulses
// Release pulses are built only when SWITCH_DEBOUNCE_RELEASE_EN is defined.
module switch_debounce #(
  parameter int DEBOUNCE_CYCLES = 250000
) (
  input  logic             i_Clk,
  input  logic             i_Rst_L,
  switch_debounce_if.slave sw
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  logic [3:0]          sync1_q, sync1_d;
  logic [3:0]          sync2_q, sync2_d;
  logic [3:0]          level_q, level_d;
  logic [3:0]          press_q, press_d;
  logic [3:0][CW-1:0]  cnt_q, cnt_d;
  logic [3:0]          accept;

  // Counter only runs while the synchronized input disagrees with the
  // accepted level; it stops at CNT_MAX because acceptance clears it.
  always_comb begin
    sync1_d = sw.i_Switch;
    sync2_d = sync1_q;
    level_d = level_q;
    cnt_d   = '0;
    accept  = '0;
    for (int ch = 0; ch < 4; ch++) begin
      if (sync2_q[ch] != level_q[ch]) begin
        if (cnt_q[ch] == CNT_MAX) begin
          accept[ch]  = 1'b1;
          level_d[ch] = sync2_q[ch];
        end else begin
          cnt_d[ch] = cnt_q[ch] + CW'(1);
        end
      end
    end
    press_d = accept & sync2_q;
  end

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      sync1_q <= '0;
      sync2_q <= '0;
      level_q <= '0;
      press_q <= '0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      level_q <= level_d;
      press_q <= press_d;
      cnt_q   <= cnt_d;
    end
  end

  assign sw.o_Level = level_q;
  assign sw.o_Press = press_q;

`ifdef SWITCH_DEBOUNCE_RELEASE_EN
  logic [3:0] release_q, release_d;

  always_comb begin
    release_d = accept & ~sync2_q;
  end

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      release_q <= '0;
    end else begin
      release_q <= release_d;
    end
  end

  assign sw.o_Release = release_q;
`endif

endmodule
